// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side monitor for a VGA hsync/vsync/rgb stream.
// Recovers pixel coordinates and colour, checks line/frame timing against
// the configured geometry, and reports lock status and timing errors.
module vga_sync_decoder #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic       pixel_valid,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [2:0] pix_rgb,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_VS    = H_SYNC + H_BACK;
  localparam int H_VE    = H_VS + H_VISIBLE;
  localparam int V_VS    = V_SYNC + V_BACK;
  localparam int V_VE    = V_VS + V_VISIBLE;
  localparam int GW      = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t          state, state_n;
  logic            hs_r, vs_r;
  logic [2:0]      rgb_r;
  logic            hs_q, vs_q;
  logic            hs_a, vs_a;
  logic            hs_rise, hs_fall, vs_rise, vs_fall;
  logic            vreset;
  logic [10:0]     hcnt, hcnt_n;
  logic [9:0]      vcnt, vcnt_n;
  logic            vpend, vpend_n;
  logic            h_err_n, v_err_n, err_n;
  logic [GW-1:0]   good, good_n;
  logic            frame_bad, frame_bad_n;
  logic            vis;

  assign hs_a = (hs_r == SYNC_POL);
  assign vs_a = (vs_r == SYNC_POL);

  // Input register stage plus previous normalised sync levels for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_r  <= ~SYNC_POL;
      vs_r  <= ~SYNC_POL;
      rgb_r <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      rgb_r <= rgb;
      hs_q  <= hs_a;
      vs_q  <= vs_a;
    end
  end

  // Counter next values and timing checks; hcnt_n/vcnt_n are the positions of
  // the sample currently in rgb_r, while hcnt/vcnt hold the previous sample's.
  always_comb begin
    hs_rise = hs_a & ~hs_q;
    hs_fall = ~hs_a & hs_q;
    vs_rise = vs_a & ~vs_q;
    vs_fall = ~vs_a & vs_q;
    vreset  = hs_rise & (vpend | vs_rise);

    hcnt_n = hcnt;
    if (hs_rise)               hcnt_n = '0;
    else if (hcnt != 11'h7FF)  hcnt_n = hcnt + 11'd1;

    vcnt_n = vcnt;
    if (vreset)                            vcnt_n = '0;
    else if (hs_rise && vcnt != 10'h3FF)   vcnt_n = vcnt + 10'd1;

    vpend_n = vreset ? 1'b0 : (vpend | vs_rise);

    h_err_n = (state != SEARCH) &&
              ((hs_rise && hcnt != 11'(H_TOTAL - 1)) ||
               (hs_fall && hcnt_n != 11'(H_SYNC)) ||
               (hcnt_n == 11'h7FF && hcnt != 11'h7FF));
    v_err_n = (state != SEARCH) &&
              ((vreset && vcnt != 10'(V_TOTAL - 1)) ||
               (vs_fall && vcnt != 10'(V_SYNC - 1)));
    err_n   = h_err_n | v_err_n;

    vis = (state == LOCKED) &&
          (hcnt_n >= 11'(H_VS)) && (hcnt_n < 11'(H_VE)) &&
          (vcnt_n >= 10'(V_VS)) && (vcnt_n < 10'(V_VE));
  end

  // Lock state machine: next state, good-frame counter and per-frame error flag
  always_comb begin
    state_n     = state;
    good_n      = good;
    frame_bad_n = frame_bad | err_n;
    case (state)
      SEARCH: begin
        if (vreset) begin
          state_n     = ACQUIRE;
          good_n      = '0;
          frame_bad_n = 1'b0;
        end
      end
      ACQUIRE: begin
        if (vreset) begin
          frame_bad_n = 1'b0;
          if (!frame_bad && !err_n) begin
            good_n = good + 1'b1;
            if (int'(good) + 1 >= LOCK_FRAMES) state_n = LOCKED;
          end
        end
        if (err_n) good_n = '0;
      end
      LOCKED: begin
        if (err_n) state_n = SEARCH;
      end
      default: state_n = SEARCH;
    endcase
  end

  // Counter and state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      hcnt      <= '0;
      vcnt      <= '0;
      vpend     <= 1'b0;
      good      <= '0;
      frame_bad <= 1'b0;
    end else begin
      state     <= state_n;
      hcnt      <= hcnt_n;
      vcnt      <= vcnt_n;
      vpend     <= vpend_n;
      good      <= good_n;
      frame_bad <= frame_bad_n;
    end
  end

  // Registered outputs, aligned with the captured colour
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_count   <= '0;
    end else begin
      pixel_valid <= vis;
      x           <= vis ? 10'(hcnt_n - 11'(H_VS)) : '0;
      y           <= vis ? 9'(vcnt_n - 10'(V_VS)) : '0;
      pix_rgb     <= vis ? rgb_r : '0;
      frame_start <= vis && (hcnt_n == 11'(H_VS)) && (vcnt_n == 10'(V_VS));
      locked      <= (state_n == LOCKED);
      h_err       <= h_err_n;
      v_err       <= v_err_n;
      if ((h_err || v_err) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a reduced 25x13 geometry.
module tb_vga_sync_decoder;

  localparam int   HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int   VV = 8,  VF = 1, VS = 2, VB = 2;
  localparam int   HT = HV + HF + HS + HB;
  localparam int   VT = VV + VF + VS + VB;
  localparam logic POL = 1'b0;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
    logic       fs;
  } px_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync, vsync;
  logic [2:0] rgb;
  logic       pixel_valid, frame_start, locked, h_err, v_err;
  logic [9:0] x;
  logic [8:0] y;
  logic [2:0] pix_rgb;
  logic [7:0] err_count;

  px_t q[$];
  px_t exp_px;
  int  npass = 0, ntotal = 0;
  bit  mon_en = 1'b0;
  int  pv_seen, fs_seen, max_x, max_y;
  int  herr_seen, verr_seen, herr_cyc, verr_cyc;
  logic lock_at_herr, lock_at_verr, lock_after_verr;
  int  cyc = 0;
  int  line_cyc;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pixel_valid(pixel_valid), .x(x), .y(y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every pixel_valid output must match the oldest expected pixel
  always @(negedge clk) begin
    if (mon_en && pixel_valid) begin
      pv_seen++;
      if (frame_start) fs_seen++;
      if (int'(x) > max_x) max_x = int'(x);
      if (int'(y) > max_y) max_y = int'(y);
      ntotal++;
      if (q.size() == 0) begin
        $display("FAIL sb_unexpected: pixel_valid got 1 expected 0 (x=%0d y=%0d)", x, y);
      end else begin
        exp_px = q.pop_front();
        if ({x, y, pix_rgb, frame_start} !== {exp_px.x, exp_px.y, exp_px.c, exp_px.fs})
          $display("FAIL sb_pixel: got x=%0d y=%0d rgb=%0d fs=%0d expected x=%0d y=%0d rgb=%0d fs=%0d",
                   x, y, pix_rgb, frame_start, exp_px.x, exp_px.y, exp_px.c, exp_px.fs);
        else npass++;
      end
    end
  end

  // Error pulse bookkeeping
  always @(negedge clk) begin
    if (h_err) begin
      if (herr_seen == 0) begin herr_cyc = cyc; lock_at_herr = locked; end
      herr_seen++;
    end
    if (v_err) begin
      if (verr_seen == 0) begin verr_cyc = cyc; lock_at_verr = locked; end
      verr_seen++;
    end
    if (verr_seen > 0 && locked) lock_after_verr = 1'b1;
  end

  task automatic drive(input logic hs_on, input logic vs_on, input logic [2:0] c);
    @(negedge clk);
    hsync = hs_on ? POL : ~POL;
    vsync = vs_on ? POL : ~POL;
    rgb   = c;
  endtask

  task automatic send_line(input int l, input int len, input int vs_lines,
                           input bit push, input bit ramp);
    int xx, yy;
    logic vis;
    logic [2:0] c;
    px_t e;
    for (int p = 0; p < len; p++) begin
      xx  = p - (HS + HB);
      yy  = l - (VS + VB);
      vis = (xx >= 0) && (xx < HV) && (yy >= 0) && (yy < VV);
      c   = 3'($urandom_range(7));
      if (ramp && vis) c = 3'(xx);
      drive(p < HS, l < vs_lines, c);
      if (p == 0) line_cyc = cyc;
      if (push && vis) begin
        e.x = 10'(xx); e.y = 9'(yy); e.c = c; e.fs = (xx == 0) && (yy == 0);
        q.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input int first, input bit push, input bit ramp);
    for (int l = first; l < VT; l++) send_line(l, HT, VS, push, ramp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (10) drive(1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    q.delete();
    herr_seen = 0; verr_seen = 0; herr_cyc = -1; verr_cyc = -1;
    lock_after_verr = 1'b0;
  endtask

  // Partial frame then two full frames: lock is due at the start of the next frame
  task automatic bring_up();
    do_reset();
    send_frame(5, 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; hsync = ~POL; vsync = ~POL; rgb = '0;
    repeat (5) @(negedge clk);
    ntotal++;
    if ({pixel_valid, x, y, pix_rgb, frame_start, locked, h_err, v_err, err_count} !== 35'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {pixel_valid, x, y, pix_rgb, frame_start, locked, h_err, v_err, err_count});
    else npass++;
    rst = 1'b1;
    repeat (20) drive(1'b0, 1'b0, 3'd5);
    ntotal++;
    if ({locked, pixel_valid, err_count} !== 10'd0)
      $display("FAIL idle_after_reset: got %h expected 0", {locked, pixel_valid, err_count});
    else npass++;
  endtask

  task automatic test_nominal();
    bring_up();
    pv_seen = 0; fs_seen = 0; max_x = -1; max_y = -1;
    mon_en = 1'b1;
    ntotal++;
    if (locked !== 1'b0) $display("FAIL lock_early: got %0b expected 0", locked); else npass++;
    send_line(0, HT, VS, 1'b1, 1'b0);
    ntotal++;
    if (locked !== 1'b1) $display("FAIL lock_rise: got %0b expected 1", locked); else npass++;
    for (int l = 1; l < VT; l++) send_line(l, HT, VS, 1'b1, 1'b0);
    send_frame(0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    ntotal++;
    if (q.size() != 0) $display("FAIL sb_leftover: got %0d expected 0", q.size()); else npass++;
    ntotal++;
    if (pv_seen != 2 * HV * VV) $display("FAIL valid_count: got %0d expected %0d", pv_seen, 2 * HV * VV);
    else npass++;
    ntotal++;
    if (fs_seen != 2) $display("FAIL frame_start_count: got %0d expected 2", fs_seen); else npass++;
    ntotal++;
    if ({herr_seen, verr_seen} != 64'd0 || err_count !== 8'd0)
      $display("FAIL nominal_errors: got h=%0d v=%0d cnt=%0d expected 0", herr_seen, verr_seen, err_count);
    else npass++;
  endtask

  task automatic test_pixel_ramp();
    bring_up();
    pv_seen = 0; fs_seen = 0; max_x = -1; max_y = -1;
    mon_en = 1'b1;
    send_frame(0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    ntotal++;
    if (max_x != HV - 1 || max_y != VV - 1)
      $display("FAIL ramp_extent: got x=%0d y=%0d expected x=%0d y=%0d", max_x, max_y, HV - 1, VV - 1);
    else npass++;
    ntotal++;
    if (q.size() != 0) $display("FAIL ramp_leftover: got %0d expected 0", q.size()); else npass++;
  endtask

  task automatic test_long_line();
    int edge_c;
    bring_up();
    send_frame(0, 1'b0, 1'b0);
    for (int l = 0; l < 10; l++) send_line(l, HT, VS, 1'b0, 1'b0);
    ntotal++;
    if (locked !== 1'b1) $display("FAIL long_pre_lock: got %0b expected 1", locked); else npass++;
    send_line(10, HT + 1, VS, 1'b0, 1'b0);
    send_line(11, HT, VS, 1'b0, 1'b0);
    edge_c = line_cyc;
    send_line(12, HT, VS, 1'b0, 1'b0);
    ntotal++;
    if (herr_seen != 1 || verr_seen != 0)
      $display("FAIL long_pulses: got h=%0d v=%0d expected h=1 v=0", herr_seen, verr_seen);
    else npass++;
    ntotal++;
    if (herr_cyc - edge_c != 2) $display("FAIL long_latency: got %0d expected 2", herr_cyc - edge_c);
    else npass++;
    ntotal++;
    if (lock_at_herr !== 1'b0) $display("FAIL long_lock_fall: got %0b expected 0", lock_at_herr);
    else npass++;
    ntotal++;
    if (err_count !== 8'd1) $display("FAIL long_err_count: got %0d expected 1", err_count); else npass++;
    send_frame(0, 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0);
    ntotal++;
    if (locked !== 1'b0) $display("FAIL relock_early: got %0b expected 0", locked); else npass++;
    send_line(0, HT, VS, 1'b0, 1'b0);
    ntotal++;
    if (locked !== 1'b1 || err_count !== 8'd1)
      $display("FAIL relock: got locked=%0b cnt=%0d expected locked=1 cnt=1", locked, err_count);
    else npass++;
  endtask

  task automatic test_vsync_long();
    int edge_c;
    bring_up();
    send_frame(0, 1'b0, 1'b0);
    ntotal++;
    if (locked !== 1'b1) $display("FAIL vlong_pre_lock: got %0b expected 1", locked); else npass++;
    edge_c = 0;
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < VT; l++) begin
        send_line(l, HT, 3, 1'b0, 1'b0);
        if (f == 0 && l == 3) edge_c = line_cyc;
      end
    ntotal++;
    if (verr_seen != 3 || herr_seen != 0)
      $display("FAIL vlong_pulses: got v=%0d h=%0d expected v=3 h=0", verr_seen, herr_seen);
    else npass++;
    ntotal++;
    if (verr_cyc - edge_c != 2) $display("FAIL vlong_latency: got %0d expected 2", verr_cyc - edge_c);
    else npass++;
    ntotal++;
    if ({lock_at_verr, lock_after_verr, locked} !== 3'b000)
      $display("FAIL vlong_no_lock: got %b expected 000", {lock_at_verr, lock_after_verr, locked});
    else npass++;
  endtask

  task automatic test_hsync_hold();
    int pvh;
    bring_up();
    send_frame(0, 1'b0, 1'b0);
    for (int l = 0; l < 6; l++) send_line(l, HT, VS, 1'b0, 1'b0);
    ntotal++;
    if (locked !== 1'b1) $display("FAIL hold_pre_lock: got %0b expected 1", locked); else npass++;
    pvh = 0;
    for (int i = 0; i < 3000; i++) begin
      drive(1'b0, 1'b0, 3'($urandom_range(7)));
      if (pixel_valid) pvh++;
    end
    ntotal++;
    if (herr_seen != 1 || pvh != 0)
      $display("FAIL hold_pulses: got h=%0d valid=%0d expected h=1 valid=0", herr_seen, pvh);
    else npass++;
    ntotal++;
    if (herr_cyc - line_cyc != 2049)
      $display("FAIL hold_saturation_time: got %0d expected 2049", herr_cyc - line_cyc);
    else npass++;
    ntotal++;
    if ({locked, err_count} !== 9'd1)
      $display("FAIL hold_state: got locked=%0b cnt=%0d expected locked=0 cnt=1", locked, err_count);
    else npass++;
  endtask

  task automatic test_err_saturate();
    do_reset();
    send_frame(5, 1'b0, 1'b0);
    send_line(0, HT, VS, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) drive(i % 2 == 0, 1'b0, 3'd0);
    ntotal++;
    if (err_count !== 8'd255) $display("FAIL err_saturate: got %0d expected 255", err_count); else npass++;
    ntotal++;
    if (herr_seen < 300) $display("FAIL err_injected: got %0d expected at least 300", herr_seen); else npass++;
    for (int i = 0; i < 40; i++) drive(i % 2 == 0, 1'b0, 3'd0);
    ntotal++;
    if (err_count !== 8'd255) $display("FAIL err_hold: got %0d expected 255", err_count); else npass++;
  endtask

  task automatic test_reset_midline();
    bring_up();
    send_frame(0, 1'b0, 1'b0);
    for (int l = 0; l < 5; l++) send_line(l, HT, VS, 1'b0, 1'b0);
    send_line(5, 12, VS, 1'b0, 1'b0);
    ntotal++;
    if ({pixel_valid, locked} !== 2'b11)
      $display("FAIL midline_pre: got %b expected 11", {pixel_valid, locked});
    else npass++;
    #2 rst = 1'b0;
    #1;
    ntotal++;
    if ({pixel_valid, x, y, pix_rgb, frame_start, locked, h_err, v_err, err_count} !== 35'd0)
      $display("FAIL midline_reset: got %h expected 0",
               {pixel_valid, x, y, pix_rgb, frame_start, locked, h_err, v_err, err_count});
    else npass++;
    repeat (10) drive(1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    send_frame(6, 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0);
    send_frame(0, 1'b0, 1'b0);
    ntotal++;
    if (locked !== 1'b0) $display("FAIL reacquire_early: got %0b expected 0", locked); else npass++;
    send_line(0, HT, VS, 1'b0, 1'b0);
    ntotal++;
    if (locked !== 1'b1) $display("FAIL reacquire: got %0b expected 1", locked); else npass++;
  endtask

  initial begin
    rst = 1'b0; hsync = ~POL; vsync = ~POL; rgb = '0;
    herr_seen = 0; verr_seen = 0; herr_cyc = -1; verr_cyc = -1;
    lock_at_herr = 1'b0; lock_at_verr = 1'b0; lock_after_verr = 1'b0;
    pv_seen = 0; fs_seen = 0; max_x = -1; max_y = -1; line_cyc = 0;
    test_reset();
    test_nominal();
    test_pixel_ramp();
    test_long_line();
    test_vsync_long();
    test_hsync_hold();
    test_err_saturate();
    test_reset_midline();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
